// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: funct3 access encodings,
// FSM state encoding, access-size helpers and writeback source selects.
package lsu_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Writeback mux selects shared with the decoder
    localparam logic [1:0] SRC_ALU  = 2'd0;
    localparam logic [1:0] SRC_DMEM = 2'd1;
    localparam logic [1:0] SRC_PC4  = 2'd2;
    localparam logic [1:0] SRC_IMM  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_RESP,
        ST_DONE
    } lsu_state_t;

    typedef enum logic [1:0] {
        SZ_BYTE,
        SZ_HALF,
        SZ_WORD
    } lsu_size_t;

    // Reserved encodings (011/110/111) fall through to word accesses
    function automatic lsu_size_t f3_size(input logic [2:0] f3);
        case (f3)
            F3_LB, F3_LBU: return SZ_BYTE;
            F3_LH, F3_LHU: return SZ_HALF;
            default:       return SZ_WORD;
        endcase
    endfunction

    function automatic logic f3_signed(input logic [2:0] f3);
        return (f3 == F3_LB) || (f3 == F3_LH);
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Request/grant/response data-memory port. The LSU is the master.
interface load_store_unit_if;
    logic        req_o;
    logic        we_o;
    logic [31:0] addr_o;
    logic [3:0]  be_o;
    logic [31:0] wdata_o;
    logic        gnt_i;
    logic        rvalid_i;
    logic [31:0] rdata_i;

    modport master (
        output req_o, we_o, addr_o, be_o, wdata_o,
        input  gnt_i, rvalid_i, rdata_i
    );

    modport slave (
        input  req_o, we_o, addr_o, be_o, wdata_o,
        output gnt_i, rvalid_i, rdata_i
    );
endinterface

// File: rtl/load_store_unit_load_align.sv
// Load lane extraction and sign/zero extension. Purely combinational so a
// future cache can reuse it on its own read path.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  offset_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] result_o
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic        sext;

    // Pick the addressed lane and extend it to 32 bits
    always_comb begin
        byte_lane = rdata_i[7:0];
        case (offset_i)
            2'd0: byte_lane = rdata_i[7:0];
            2'd1: byte_lane = rdata_i[15:8];
            2'd2: byte_lane = rdata_i[23:16];
            2'd3: byte_lane = rdata_i[31:24];
            default: byte_lane = rdata_i[7:0];
        endcase
        // offset bit 0 is ignored for halves: non-trapping builds treat the
        // access as naturally aligned
        half_lane = offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        sext      = f3_signed(funct3_i);
        result_o  = rdata_i;
        case (f3_size(funct3_i))
            SZ_BYTE: result_o = {{24{sext & byte_lane[7]}}, byte_lane};
            SZ_HALF: result_o = {{16{sext & half_lane[15]}}, half_lane};
            default: result_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory access stage: issues one bus transaction per load/store,
// stalls the core while it is in flight and returns extended load data.
// Optional feature macro: LSU_MISALIGN_TRAP_EN (misaligned half/word accesses
// complete immediately with misaligned_o instead of touching the bus).
//
//   state   | meaning
//   --------+--------------------------------------------------------
//   IDLE    | waiting for a valid load/store
//   REQ     | req_o high, bus fields held until gnt_i
//   RESP    | load granted, waiting for rvalid_i
//   DONE    | done_o pulse, core advances; nothing accepted here
module load_store_unit
    import lsu_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        valid_i,
    input  logic        mem_read_i,
    input  logic        mem_write_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        stall_o,
    output logic        done_o,
    output logic [31:0] rdata_o,
    output logic        misaligned_o,
    load_store_unit_if.master mem
);

    lsu_state_t  state;
    logic        is_load;
    logic [2:0]  funct3_q;
    logic [1:0]  offset_q;
    logic        req_q;
    logic        we_q;
    logic [31:0] addr_q;
    logic [3:0]  be_q;
    logic [31:0] wdata_q;

    logic        accept;
    logic        misaligned;
    logic [3:0]  be_next;
    logic [31:0] wdata_next;
    logic [31:0] load_result;

    assign accept = valid_i && (mem_read_i || mem_write_i);

    assign mem.req_o   = req_q;
    assign mem.we_o    = we_q;
    assign mem.addr_o  = addr_q;
    assign mem.be_o    = be_q;
    assign mem.wdata_o = wdata_q;

    // Hold the pipeline from the accept cycle until the access resolves
    always_comb begin
        stall_o = ((state == ST_IDLE) && accept)
               || (state == ST_REQ)
               || (state == ST_RESP);
    end

    // Byte enables and lane-replicated store data for the incoming access
    always_comb begin
        be_next    = 4'b1111;
        wdata_next = wdata_i;
        case (f3_size(funct3_i))
            SZ_BYTE: begin
                be_next    = 4'b0001 << addr_i[1:0];
                wdata_next = {4{wdata_i[7:0]}};
            end
            SZ_HALF: begin
                be_next    = 4'b0011 << {addr_i[1], 1'b0};
                wdata_next = {2{wdata_i[15:0]}};
            end
            default: begin
                be_next    = 4'b1111;
                wdata_next = wdata_i;
            end
        endcase
    end

`ifdef LSU_MISALIGN_TRAP_EN
    // Halves need addr[0]=0, words need addr[1:0]=0
    always_comb begin
        misaligned = 1'b0;
        case (f3_size(funct3_i))
            SZ_HALF: misaligned = addr_i[0];
            SZ_WORD: misaligned = |addr_i[1:0];
            default: misaligned = 1'b0;
        endcase
    end
`else
    assign misaligned = 1'b0;
`endif

    lsu_load_align u_load_align (
        .rdata_i  (mem.rdata_i),
        .offset_i (offset_q),
        .funct3_i (funct3_q),
        .result_o (load_result)
    );

    // Access sequencer with registered bus and completion outputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state        <= ST_IDLE;
            is_load      <= 1'b0;
            funct3_q     <= 3'b000;
            offset_q     <= 2'b00;
            req_q        <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= 32'h0;
            be_q         <= 4'h0;
            wdata_q      <= 32'h0;
            rdata_o      <= 32'h0;
            done_o       <= 1'b0;
            misaligned_o <= 1'b0;
        end else begin
            done_o       <= 1'b0;
            misaligned_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        is_load  <= mem_read_i;
                        funct3_q <= funct3_i;
                        offset_q <= addr_i[1:0];
                        if (misaligned) begin
                            state        <= ST_DONE;
                            done_o       <= 1'b1;
                            misaligned_o <= 1'b1;
                        end else begin
                            state   <= ST_REQ;
                            req_q   <= 1'b1;
                            we_q    <= ~mem_read_i;
                            addr_q  <= {addr_i[31:2], 2'b00};
                            be_q    <= be_next;
                            wdata_q <= wdata_next;
                        end
                    end
                end
                ST_REQ: begin
                    if (mem.gnt_i) begin
                        req_q <= 1'b0;
                        if (is_load) begin
                            state <= ST_RESP;
                        end else begin
                            state  <= ST_DONE;
                            done_o <= 1'b1;
                        end
                    end
                end
                ST_RESP: begin
                    if (mem.rvalid_i) begin
                        rdata_o <= load_result;
                        state   <= ST_DONE;
                        done_o  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: stores, loads of every size, grant and
// response wait states, misaligned word load and reset during a response.
module tb_load_store_unit;
    import lsu_pkg::*;

    logic        clk;
    logic        rst;
    logic        valid;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stall;
    logic        done;
    logic [31:0] rdata;
    logic        misaligned;

    int n_checks = 0;
    int n_errors = 0;

    load_store_unit_if mem ();

    load_store_unit dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .valid_i      (valid),
        .mem_read_i   (mem_read),
        .mem_write_i  (mem_write),
        .funct3_i     (funct3),
        .addr_i       (addr),
        .wdata_i      (wdata),
        .stall_o      (stall),
        .done_o       (done),
        .rdata_o      (rdata),
        .misaligned_o (misaligned),
        .mem          (mem.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled just after the falling edge
    task automatic tick;
        @(negedge clk);
    endtask

    task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] word, input logic [31:0] exp);
        valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; funct3 = f3; addr = a;
        mem.gnt_i = 1'b1;
        tick;
        valid = 1'b0; mem_read = 1'b0;
        chk({tag, "_we"}, {31'b0, mem.we_o}, 32'd0);
        tick;
        mem.gnt_i = 1'b0; mem.rvalid_i = 1'b1; mem.rdata_i = word;
        tick;
        mem.rvalid_i = 1'b0;
        chk({tag, "_done"}, {31'b0, done}, 32'd1);
        chk(tag, rdata, exp);
        tick;
    endtask

    initial begin
        rst = 1'b1; valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        funct3 = 3'b000; addr = 32'h0; wdata = 32'h0;
        mem.gnt_i = 1'b0; mem.rvalid_i = 1'b0; mem.rdata_i = 32'h0;
        tick; tick;
        rst = 1'b0;

        // Reset state
        chk("rst_req",   {31'b0, mem.req_o}, 32'd0);
        chk("rst_we",    {31'b0, mem.we_o},  32'd0);
        chk("rst_addr",  mem.addr_o,         32'd0);
        chk("rst_be",    {28'b0, mem.be_o},  32'd0);
        chk("rst_wdata", mem.wdata_o,        32'd0);
        chk("rst_rdata", rdata,              32'd0);
        chk("rst_done",  {31'b0, done},      32'd0);
        chk("rst_mis",   {31'b0, misaligned}, 32'd0);
        chk("rst_stall", {31'b0, stall},     32'd0);

        // SW 0x104 with immediate grant
        valid = 1'b1; mem_write = 1'b1; funct3 = F3_LW; addr = 32'h104; wdata = 32'hDEADBEEF;
        mem.gnt_i = 1'b1;
        #1 chk("sw_stall_acc", {31'b0, stall}, 32'd1);
        tick;
        valid = 1'b0; mem_write = 1'b0;
        chk("sw_req",   {31'b0, mem.req_o}, 32'd1);
        chk("sw_we",    {31'b0, mem.we_o},  32'd1);
        chk("sw_addr",  mem.addr_o,         32'h104);
        chk("sw_be",    {28'b0, mem.be_o},  32'hF);
        chk("sw_wdata", mem.wdata_o,        32'hDEADBEEF);
        chk("sw_stall_req", {31'b0, stall}, 32'd1);
        chk("sw_done_early", {31'b0, done}, 32'd0);
        tick;
        mem.gnt_i = 1'b0;
        chk("sw_done",  {31'b0, done},      32'd1);
        chk("sw_stall_done", {31'b0, stall}, 32'd0);
        chk("sw_req_drop", {31'b0, mem.req_o}, 32'd0);
        tick;
        chk("sw_done_pulse", {31'b0, done}, 32'd0);

        // SB 0x103
        valid = 1'b1; mem_write = 1'b1; funct3 = F3_LB; addr = 32'h103; wdata = 32'h000000A5;
        mem.gnt_i = 1'b1;
        tick;
        valid = 1'b0; mem_write = 1'b0;
        chk("sb_be",    {28'b0, mem.be_o}, 32'h8);
        chk("sb_wdata", mem.wdata_o,       32'hA5A5A5A5);
        chk("sb_addr",  mem.addr_o,        32'h100);
        tick;
        mem.gnt_i = 1'b0;
        chk("sb_done", {31'b0, done}, 32'd1);
        tick;

        // SH 0x102: upper half lanes
        valid = 1'b1; mem_write = 1'b1; funct3 = F3_LH; addr = 32'h102; wdata = 32'h0000BEEF;
        mem.gnt_i = 1'b1;
        tick;
        valid = 1'b0; mem_write = 1'b0;
        chk("sh_be",    {28'b0, mem.be_o}, 32'hC);
        chk("sh_wdata", mem.wdata_o,       32'hBEEFBEEF);
        tick;
        mem.gnt_i = 1'b0;
        tick;

        // Loads of every size
        do_load("lb",   F3_LB,  32'h102, 32'h12805634, 32'hFFFFFF80);
        do_load("lbu",  F3_LBU, 32'h102, 32'h12805634, 32'h00000080);
        do_load("lhu",  F3_LHU, 32'h102, 32'h12805634, 32'h00001280);
        do_load("lh0",  F3_LH,  32'h100, 32'h00008001, 32'hFFFF8001);
        do_load("lhu0", F3_LHU, 32'h100, 32'h00008001, 32'h00008001);
        do_load("lb1",  F3_LB,  32'h101, 32'h00007F00, 32'h0000007F);
        do_load("lw",   F3_LW,  32'h100, 32'h12805634, 32'h12805634);

        // Grant withheld 3 cycles, stray rvalid in REQ, response 2 cycles late
        valid = 1'b1; mem_read = 1'b1; funct3 = F3_LW; addr = 32'h200;
        tick;
        valid = 1'b0; mem_read = 1'b0;
        for (int i = 0; i < 3; i++) begin
            mem.rvalid_i = (i == 1);
            mem.rdata_i  = 32'h11111111;
            chk($sformatf("gw_req%0d", i),   {31'b0, mem.req_o}, 32'd1);
            chk($sformatf("gw_addr%0d", i),  mem.addr_o,         32'h200);
            chk($sformatf("gw_stall%0d", i), {31'b0, stall},     32'd1);
            chk($sformatf("gw_done%0d", i),  {31'b0, done},      32'd0);
            tick;
        end
        mem.rvalid_i = 1'b0;
        chk("gw_req_hold", {31'b0, mem.req_o}, 32'd1);
        mem.gnt_i = 1'b1;
        tick;
        mem.gnt_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("rw_stall%0d", i), {31'b0, stall},     32'd1);
            chk($sformatf("rw_done%0d", i),  {31'b0, done},      32'd0);
            chk($sformatf("rw_req%0d", i),   {31'b0, mem.req_o}, 32'd0);
            tick;
        end
        mem.rvalid_i = 1'b1; mem.rdata_i = 32'hCAFEF00D;
        tick;
        mem.rvalid_i = 1'b0;
        chk("rw_done",  {31'b0, done},  32'd1);
        chk("rw_rdata", rdata,          32'hCAFEF00D);
        chk("rw_stall", {31'b0, stall}, 32'd0);
        tick;

        // LW at 0x101
        valid = 1'b1; mem_read = 1'b1; funct3 = F3_LW; addr = 32'h101;
        tick;
        valid = 1'b0; mem_read = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
        chk("mis_req",   {31'b0, mem.req_o},  32'd0);
        chk("mis_done",  {31'b0, done},       32'd1);
        chk("mis_flag",  {31'b0, misaligned}, 32'd1);
        chk("mis_rdata", rdata,               32'hCAFEF00D);
        tick;
        chk("mis_pulse", {31'b0, misaligned}, 32'd0);
`else
        chk("mis_req",   {31'b0, mem.req_o},  32'd1);
        chk("mis_addr",  mem.addr_o,          32'h100);
        chk("mis_be",    {28'b0, mem.be_o},   32'hF);
        chk("mis_flag",  {31'b0, misaligned}, 32'd0);
        mem.gnt_i = 1'b1;
        tick;
        mem.gnt_i = 1'b0; mem.rvalid_i = 1'b1; mem.rdata_i = 32'h55667788;
        tick;
        mem.rvalid_i = 1'b0;
        chk("mis_done",  {31'b0, done},       32'd1);
        chk("mis_rdata", rdata,               32'h55667788);
        chk("mis_none",  {31'b0, misaligned}, 32'd0);
`endif
        tick;

        // Reset while waiting for a response
        valid = 1'b1; mem_read = 1'b1; funct3 = F3_LW; addr = 32'h300;
        mem.gnt_i = 1'b1;
        tick;
        valid = 1'b0; mem_read = 1'b0;
        tick;
        mem.gnt_i = 1'b0;
        chk("rr_in_resp", {31'b0, stall}, 32'd1);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk("rr_req",   {31'b0, mem.req_o}, 32'd0);
        chk("rr_addr",  mem.addr_o,         32'd0);
        chk("rr_be",    {28'b0, mem.be_o},  32'd0);
        chk("rr_rdata", rdata,              32'd0);
        chk("rr_stall", {31'b0, stall},     32'd0);
        chk("rr_done",  {31'b0, done},      32'd0);
        mem.rvalid_i = 1'b1; mem.rdata_i = 32'h99999999;
        tick;
        mem.rvalid_i = 1'b0;
        chk("rr_late_done",  {31'b0, done}, 32'd0);
        tick;
        chk("rr_late_done2", {31'b0, done}, 32'd0);
        chk("rr_late_rdata", rdata,         32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
